// File: rtl/alu_result_uart_tx_pkg.sv
// alu_tx_pkg: shared definitions for the ALU result UART transmitter.
//   - state_t       : transmitter FSM states (also exported for debug)
//   - TICKS_PER_BIT : oversampling ticks per serial bit
//   - BYTE_RES/BYTE_FLAGS : selects which byte of the pair is on the line
//   - FLAG_CARRY/FLAG_ZERO : bit positions inside the flags byte
// Optional feature macro: ALU_TX_PARITY_EN (adds ST_PARITY to each frame).
package alu_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int TICKS_PER_BIT = 16;

  localparam logic BYTE_RES   = 1'b0;
  localparam logic BYTE_FLAGS = 1'b1;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// alu_result_uart_tx_if: groups the ALU-side request and the line/status
// outputs of alu_result_uart_tx.
//   i_res[NB_DATA], i_carry, i_send : request side (master drives)
//   o_tx, o_busy, o_done, o_state   : line and status (slave drives)
//
// Handshake: i_send is a level request sampled only while the transmitter is
// idle; there is no ready signal. A request is accepted on the first rising
// edge where i_send=1 and o_busy=0 (this includes the o_done cycle). While
// o_busy=1, i_send is ignored and nothing is queued. o_done pulses for one
// cycle when the second frame of a pair has finished.
interface alu_result_uart_tx_if #(
  parameter int NB_DATA = 8
) ();
  import alu_tx_pkg::*;

  logic [NB_DATA-1:0] i_res;
  logic               i_carry;
  logic               i_send;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;
  state_t             o_state;

  modport master (
    output i_res, i_carry, i_send,
    input  o_tx, o_busy, o_done, o_state
  );

  modport slave (
    input  i_res, i_carry, i_send,
    output o_tx, o_busy, o_done, o_state
  );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: emits a one-cycle tick every DIV clocks while enabled.
//   i_clk   : system clock
//   i_reset : asynchronous active-low reset
//   i_en    : enable; the counter is held at 0 while low so the first tick
//             lands exactly DIV clocks after enable rises
//   o_tick  : one-cycle tick
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (!i_en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = i_en && (cnt_q == LAST);
endmodule

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: sends the ALU result byte and a flags byte
// ({zeros, zero, carry}) as two back-to-back UART frames, LSB first.
//   i_clk   : system clock, all state on rising edge
//   i_reset : asynchronous active-low reset (line forced high, pair aborted)
//   bus     : alu_result_uart_tx_if.slave (i_res, i_carry, i_send, o_tx,
//             o_busy, o_done, o_state)
// Parameters: NB_DATA, CLK_FREQ_HZ, BAUD_RATE; DIV = CLK_FREQ_HZ/(BAUD_RATE*16)
// is derived and must be at least 1.
// Optional feature macro: ALU_TX_PARITY_EN adds an even-parity bit per frame.
module alu_result_uart_tx
  import alu_tx_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  alu_result_uart_tx_if.slave  bus
);
  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * 16);
  localparam int TCW = $clog2(TICKS_PER_BIT);
  localparam int BW  = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

  state_t             state_q, state_n;
  logic [TCW-1:0]     tick_cnt_q, tick_cnt_n;
  logic [BW-1:0]      bit_q, bit_n;
  logic               byte_q, byte_n;
  logic [NB_DATA-1:0] res_q, res_n;
  logic [NB_DATA-1:0] flags_q, flags_n;
  logic [NB_DATA-1:0] cur_byte;
  logic               tx_q, tx_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               tick;
  logic               last_tick;

  // Bit timing restarts at acceptance because the divider is held while idle.
  baud_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (state_q != ST_IDLE),
    .o_tick  (tick)
  );

  assign last_tick = tick && (tick_cnt_q == TCW'(TICKS_PER_BIT - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_q      <= '0;
      byte_q     <= BYTE_RES;
      res_q      <= '0;
      flags_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_cnt_q <= tick_cnt_n;
      bit_q      <= bit_n;
      byte_q     <= byte_n;
      res_q      <= res_n;
      flags_q    <= flags_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    tick_cnt_n = tick_cnt_q;
    bit_n      = bit_q;
    byte_n     = byte_q;
    res_n      = res_q;
    flags_n    = flags_q;
    done_n     = 1'b0;
    tx_n       = 1'b1;
    cur_byte   = '0;

    // 4-bit tick counter wraps to 0 on the last tick of every bit.
    if (tick) tick_cnt_n = tick_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_n = '0;
        if (bus.i_send) begin
          res_n              = bus.i_res;
          flags_n            = '0;
          flags_n[FLAG_CARRY] = bus.i_carry;
          flags_n[FLAG_ZERO]  = (bus.i_res == '0);
          byte_n             = BYTE_RES;
          bit_n              = '0;
          state_n            = ST_START;
        end
      end
      ST_START: begin
        if (last_tick) begin
          bit_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          if (bit_q == BW'(NB_DATA - 1)) begin
`ifdef ALU_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
`ifdef ALU_TX_PARITY_EN
      ST_PARITY: begin
        if (last_tick) state_n = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (last_tick) begin
          if (byte_q == BYTE_RES) begin
            // Flags frame follows immediately, no idle gap.
            byte_n  = BYTE_FLAGS;
            state_n = ST_START;
          end else begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered: decode the line level from the next state so
    // the pin changes on the same edge as the state.
    cur_byte = (byte_n == BYTE_RES) ? res_n : flags_n;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = cur_byte[bit_n];
`ifdef ALU_TX_PARITY_EN
      ST_PARITY: tx_n = ^cur_byte;
`endif
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  assign bus.o_tx    = tx_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_state = state_q;
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx with DIV=1 (16 clocks per bit).
module tb_alu_result_uart_tx;
  import alu_tx_pkg::*;

`ifdef ALU_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int PAIR = 2 * FRAME_BITS * 16;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic [7:0] exp_flags;
    int         poke_at;
  } vec_t;

  logic i_clk;
  logic i_reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q[$];

  alu_result_uart_tx_if #(.NB_DATA(8)) bus ();

  alu_result_uart_tx #(
    .NB_DATA     (8),
    .CLK_FREQ_HZ (1_600_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // line monitor: decodes frames mid-bit and pops the scoreboard
  logic       mon_active;
  logic       mon_prev;
  int         mon_cnt;
  logic [7:0] mon_shift;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      mon_active <= 1'b0;
      mon_prev   <= 1'b1;
      mon_cnt    <= 0;
    end else if (!mon_active) begin
      if (mon_prev && !bus.o_tx) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
      mon_prev <= bus.o_tx;
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt % 16 == 8) begin
        if (mon_cnt / 16 == 0) begin
          check("start_bit", {31'b0, bus.o_tx}, 32'd0);
        end else if (mon_cnt / 16 <= 8) begin
          mon_shift <= {bus.o_tx, mon_shift[7:1]};
`ifdef ALU_TX_PARITY_EN
        end else if (mon_cnt / 16 == 9) begin
          check("parity_bit", {31'b0, bus.o_tx}, {31'b0, ^mon_shift});
`endif
        end else begin
          check("stop_bit", {31'b0, bus.o_tx}, 32'd1);
          if (exp_q.size() == 0)
            check("frame_unexpected", {24'b0, mon_shift}, 32'hFFFF_FFFF);
          else
            check("frame_byte", {24'b0, mon_shift}, {24'b0, exp_q.pop_front()});
          mon_active <= 1'b0;
          mon_prev   <= 1'b1;
        end
      end
    end
  end

  // driver: one request, then track busy/done until the pair ends
  task automatic run_pair(input logic [7:0] res, input logic c,
                          input logic [7:0] exp_flags, input int poke_at);
    int cyc;
    int busy_cnt;
    int stray;
    bus.i_res   = res;
    bus.i_carry = c;
    bus.i_send  = 1'b1;
    exp_q.push_back(res);
    exp_q.push_back(exp_flags);
    @(negedge i_clk);
    bus.i_send  = 1'b0;
    bus.i_res   = ~res;
    bus.i_carry = ~c;
    check("accept_tx", {31'b0, bus.o_tx}, 32'd0);
    check("accept_busy", {31'b0, bus.o_busy}, 32'd1);
    cyc      = 0;
    busy_cnt = 1;
    while (bus.o_done !== 1'b1 && cyc < PAIR + 50) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == poke_at) begin
        bus.i_send = 1'b1;
        bus.i_res  = 8'hFF;
      end else if (cyc == poke_at + 1) begin
        bus.i_send = 1'b0;
      end
      if (bus.o_busy) busy_cnt++;
    end
    check("done_latency", cyc, PAIR);
    check("busy_cycles", busy_cnt, PAIR);
    check("busy_low_at_done", {31'b0, bus.o_busy}, 32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus.o_busy || bus.o_done) stray++;
    end
    check("no_extra_activity", stray, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc;
    int   stray;
    logic prev_busy;
    int   done_at[$];
    int   start_at[$];
    logic [7:0] r;
    logic       c;

    vecs[0] = '{res: 8'hA5, carry: 1'b1, exp_flags: 8'h01, poke_at: -1};
    vecs[1] = '{res: 8'h00, carry: 1'b0, exp_flags: 8'h02, poke_at: -1};
    vecs[2] = '{res: 8'h3C, carry: 1'b0, exp_flags: 8'h00, poke_at: 50};
    vecs[3] = '{res: 8'hFF, carry: 1'b1, exp_flags: 8'h01, poke_at: -1};
    vecs[4] = '{res: 8'h00, carry: 1'b1, exp_flags: 8'h03, poke_at: -1};
    vecs[5] = '{res: 8'h07, carry: 1'b0, exp_flags: 8'h00, poke_at: -1};
    vecs[6] = '{res: 8'h80, carry: 1'b0, exp_flags: 8'h00, poke_at: -1};

    n_checks    = 0;
    n_errors    = 0;
    i_reset     = 1'b0;
    bus.i_res   = '0;
    bus.i_carry = 1'b0;
    bus.i_send  = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_tx", {31'b0, bus.o_tx}, 32'd1);
    check("reset_busy", {31'b0, bus.o_busy}, 32'd0);
    check("reset_done", {31'b0, bus.o_done}, 32'd0);
    check("reset_state", {29'b0, bus.o_state}, {29'b0, ST_IDLE});
    i_reset = 1'b1;
    @(negedge i_clk);
    check("idle_tx", {31'b0, bus.o_tx}, 32'd1);

    // table-driven pairs
    foreach (vecs[i]) run_pair(vecs[i].res, vecs[i].carry, vecs[i].exp_flags, vecs[i].poke_at);

    // random pairs with flags from a small model
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      run_pair(r, c, {6'b0, (r == 8'h00), c}, -1);
    end

    // reset in the middle of a data bit
    bus.i_res   = 8'h81;
    bus.i_carry = 1'b0;
    bus.i_send  = 1'b1;
    @(negedge i_clk);
    bus.i_send = 1'b0;
    stray = 0;
    for (int i = 0; i < 39; i++) begin
      @(negedge i_clk);
      if (bus.o_done) stray++;
    end
    #2 i_reset = 1'b0;
    #1;
    check("abort_tx", {31'b0, bus.o_tx}, 32'd1);
    check("abort_busy", {31'b0, bus.o_busy}, 32'd0);
    check("abort_state", {29'b0, bus.o_state}, {29'b0, ST_IDLE});
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (bus.o_done || bus.o_busy) stray++;
    end
    check("abort_no_done", stray, 0);
    run_pair(8'h55, 1'b0, 8'h00, -1);

    // send held high: a new pair starts in every o_done cycle
    bus.i_res   = 8'h12;
    bus.i_carry = 1'b0;
    bus.i_send  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h00);
    end
    @(negedge i_clk);
    check("held_first_busy", {31'b0, bus.o_busy}, 32'd1);
    cyc       = 0;
    prev_busy = bus.o_busy;
    while (done_at.size() < 3 && cyc < 4 * PAIR) begin
      @(negedge i_clk);
      cyc++;
      if (bus.o_done) done_at.push_back(cyc);
      if (bus.o_busy && !prev_busy) begin
        start_at.push_back(cyc);
        if (start_at.size() == 2) bus.i_send = 1'b0;
      end
      prev_busy = bus.o_busy;
    end
    check("held_done_count", done_at.size(), 3);
    check("held_start_count", start_at.size(), 2);
    if (done_at.size() >= 3) begin
      check("held_done0", done_at[0], PAIR);
      check("held_done1", done_at[1], 2 * PAIR + 1);
      check("held_done2", done_at[2], 3 * PAIR + 2);
    end
    if (start_at.size() >= 2) begin
      check("held_start1", start_at[0], PAIR + 1);
      check("held_start2", start_at[1], 2 * PAIR + 2);
    end
    repeat (20) @(negedge i_clk);
    check("held_idle_busy", {31'b0, bus.o_busy}, 32'd0);
    check("held_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
